image_stream_reader: RTL and testbench
======================================

IMAGE_STREAM_READER -- requirements
Module: image_stream_reader

Interface
REQ-001 Parameter ADDR_DEPTH, default 16384, pixels per frame (128x128).
REQ-002 Parameter DATA_WIDTH, default 16, pixel width (RGB565).
REQ-003 Parameter H_PIXELS, default 128, pixels per line; ADDR_DEPTH SHALL be a multiple of H_PIXELS.
REQ-004 Parameter ADDR_WIDTH, default clog2(ADDR_DEPTH), memory address width.
REQ-005 clk_i  in  1  single clock; all logic SHALL run on its rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 start_i  in  1  pulse to begin a frame; ignored unless idle.
REQ-008 abort_i  in  1  stop the frame and flush.
REQ-009 rd_en_o  out  1  read strobe to the image memory (registered-read mode).
REQ-010 rd_addr_o  out  ADDR_WIDTH  read address.
REQ-011 rd_data_i  in  DATA_WIDTH  memory read data, valid exactly 1 cycle after rd_en_o.
REQ-012 m_valid_o / m_ready_i  out/in  1  downstream pixel handshake.
REQ-013 m_data_o  out  DATA_WIDTH  pixel.
REQ-014 m_sof_o, m_eol_o, m_eof_o  out  1 each  first pixel of frame, last pixel of line, last pixel of frame; qualified by m_valid_o.
REQ-015 busy_o  out  1  high while not IDLE.
REQ-016 done_o  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-017 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-018 IDLE->RUN on start_i; read address counter loads 0.
REQ-019 In RUN, rd_en_o SHALL assert only when (FIFO count + reads in flight) < 2; rd_addr_o increments by 1 per issued read.
REQ-020 Issuing address ADDR_DEPTH-1 SHALL move RUN->DRAIN.
REQ-021 DRAIN->IDLE when FIFO is empty and no read is in flight; done_o pulses on the handshake of the m_eof_o pixel.
REQ-022 Returned data SHALL enter a 2-entry output FIFO with its tags; sof for address 0, eol when address mod H_PIXELS = H_PIXELS-1, eof for address ADDR_DEPTH-1.
REQ-023 A pixel transfers when m_valid_o and m_ready_i are both high; m_data_o and tags SHALL stay stable while m_valid_o=1 and m_ready_i=0.
REQ-024 Sustained m_ready_i=1 SHALL yield one pixel per cycle after a 2-cycle initial latency (start_i to first m_valid_o).
REQ-025 Simultaneous FIFO push and pop SHALL keep count unchanged; the FIFO SHALL never overflow.
REQ-026 abort_i in any state SHALL, next cycle, force IDLE, clear FIFO and in-flight flag, deassert m_valid_o; the in-flight read data SHALL be discarded; abort_i takes priority over start_i.
REQ-027 start_i while busy_o=1 SHALL be ignored.

Reset
REQ-028 On rst_i: state IDLE, address 0, FIFO empty, in-flight 0.
REQ-029 Reset values: rd_en_o=0, rd_addr_o=0, m_valid_o=0, m_data_o=0, tags=0, busy_o=0, done_o=0.
REQ-030 Reset mid-frame SHALL behave as REQ-028/029 with no residual output.

Configuration
REQ-031 Macro IMAGE_STREAM_LOOP_EN: when defined, issuing address ADDR_DEPTH-1 SHALL wrap the address to 0 and remain in RUN (continuous refresh, done_o still pulses per frame, only abort_i/rst_i stop it); when undefined, REQ-020/021 single-shot behaviour applies.

Structure
REQ-032 A shared package SHALL hold the FSM state typedef, default geometry constants (128, 128, 16) and the clog2 function.
REQ-033 The 2-entry output FIFO with tags SHALL be one sub-module, image_stream_skid_fifo.

Verification
REQ-034 ADDR_DEPTH=16, H_PIXELS=4, memory preloaded addr=data, m_ready_i=1, start_i pulse -> data 0..15 on 16 consecutive cycles, sof on 0, eol on 3/7/11/15, eof+done_o on 15, then busy_o=0.
REQ-035 Same, m_ready_i toggling 1/0 each cycle -> same 0..15 order, no loss/duplication, data stable while stalled.
REQ-036 m_ready_i=0 for 10 cycles after start -> at most 2 reads issued, FIFO holds 0,1; release -> stream continues 2..15.
REQ-037 abort_i at pixel 5 -> next cycle m_valid_o=0, busy_o=0; new start_i restarts at data 0 with sof.
REQ-038 With IMAGE_STREAM_LOOP_EN, m_ready_i=1 -> data 15 followed immediately by 0 with sof, done_o pulsing once per 16 pixels.
REQ-039 rst_i asserted at pixel 7 -> all outputs at reset values next cycle; start_i ignored while busy in a separate run.

Source files
------------

// File: rtl/image_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// image_stream_reader_pkg
//   Shared definitions for the image stream reader:
//     - state_t       : reader FSM states (IDLE / RUN / DRAIN)
//     - pixel_tags_t  : per-pixel framing tags {sof, eol, eof}
//     - DEFAULT_*     : default frame geometry (128 x 128, 16-bit RGB565)
//     - clog2()       : constant-evaluable ceiling log2 (never returns < 1)
//   No ports; imported by image_stream_reader and image_stream_skid_fifo.
// ---------------------------------------------------------------------------
package image_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Packed so that {sof, eol, eof} maps to bits [2:0] of a plain vector.
  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pixel_tags_t;

  localparam int DEFAULT_H_PIXELS   = 128;
  localparam int DEFAULT_V_LINES    = 128;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_DEPTH = DEFAULT_H_PIXELS * DEFAULT_V_LINES;

  // Minimum result of 1 keeps derived vector widths legal for depth 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/image_stream_reader_skid_fifo.sv
// ---------------------------------------------------------------------------
// image_stream_skid_fifo
//   Two-entry output FIFO holding a pixel plus its framing tags.
//   Ports:
//     clk        : clock, rising edge
//     rst        : synchronous active-high reset
//     flush      : synchronous clear of pointers/count (used by abort)
//     push       : write push_data/push_tags this cycle
//     push_data  : pixel data in
//     push_tags  : {sof, eol, eof} in
//     pop        : consume the head entry this cycle
//     valid      : FIFO non-empty (head entry presented)
//     data       : head pixel data, forced to 0 while empty
//     tags       : head {sof, eol, eof}, forced to 0 while empty
//     count      : number of occupied entries (0..2)
//   A simultaneous push and pop keeps the count unchanged. A push into a
//   full FIFO without a pop is dropped so the storage can never be overrun.
// ---------------------------------------------------------------------------
module image_stream_skid_fifo
  import image_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [2:0]            push_tags,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [2:0]            tags,
  output logic [1:0]            count
);

  localparam int ENTRIES = 2;

  logic [DATA_WIDTH-1:0] data_arr [ENTRIES];
  pixel_tags_t           tags_arr [ENTRIES];

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0] count_next;
  logic       push_ok;
  logic       pop_ok;

  assign pop_ok  = pop && (count_reg != 2'd0);
  assign push_ok = push && ((count_reg != 2'd2) || pop_ok);

  // One storage register per entry; each only ever loads when the write
  // pointer selects it.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] entry_data_reg;
      pixel_tags_t           entry_tags_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_data_reg <= '0;
          entry_tags_reg <= '0;
        end else if (push_ok && (wr_ptr_reg == 1'(gi))) begin
          entry_data_reg <= push_data;
          entry_tags_reg <= push_tags;
        end
      end

      assign data_arr[gi] = entry_data_reg;
      assign tags_arr[gi] = entry_tags_reg;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (pop_ok) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
    end
  end

  // Gating the head with valid keeps stale entries off the bus after a
  // flush or once the frame has drained.
  assign valid = (count_reg != 2'd0);
  assign data  = valid ? data_arr[rd_ptr_reg] : '0;
  assign tags  = valid ? tags_arr[rd_ptr_reg] : 3'b000;
  assign count = count_reg;

endmodule

// File: rtl/image_stream_reader.sv
// ---------------------------------------------------------------------------
// image_stream_reader
//   Reads one frame of pixels from a registered-read image memory and
//   streams it out over a valid/ready handshake with sof/eol/eof tags.
//   Parameters:
//     ADDR_DEPTH : pixels per frame (multiple of H_PIXELS)
//     DATA_WIDTH : pixel width
//     H_PIXELS   : pixels per line
//     ADDR_WIDTH : memory address width
//   Ports:
//     clk_i, rst_i       : clock (rising edge) and synchronous active-high reset
//     start_i            : begin a frame (only honoured while idle)
//     abort_i            : stop the frame, flush queued and in-flight pixels
//     rd_en_o, rd_addr_o : memory read strobe / address
//     rd_data_i          : memory data, valid one cycle after rd_en_o
//     m_valid_o/m_ready_i: downstream handshake
//     m_data_o           : pixel
//     m_sof_o/m_eol_o/m_eof_o : framing tags, qualified by m_valid_o
//     busy_o             : high while not idle
//     done_o             : one-cycle pulse when the eof pixel is accepted
//   Build option:
//     IMAGE_STREAM_LOOP_EN : when defined, the last address wraps to 0 and the
//                            reader keeps refreshing until abort_i / rst_i.
// ---------------------------------------------------------------------------
module image_stream_reader
  import image_stream_reader_pkg::*;
#(
  parameter int ADDR_DEPTH = DEFAULT_ADDR_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int H_PIXELS   = DEFAULT_H_PIXELS,
  parameter int ADDR_WIDTH = clog2(ADDR_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_sof_o,
  output logic                  m_eol_o,
  output logic                  m_eof_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // Column is tracked with its own counter so eol needs no modulo by a
  // possibly non-power-of-two line length.
  localparam int                    COL_WIDTH = clog2(H_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_DEPTH - 1);
  localparam logic [COL_WIDTH-1:0]  LAST_COL  = COL_WIDTH'(H_PIXELS - 1);

  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [COL_WIDTH-1:0]  col_reg;
  logic [COL_WIDTH-1:0]  col_next;
  logic                  inflight_reg;
  pixel_tags_t           inflight_tags_reg;
  pixel_tags_t           issue_tags;

  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [2:0]            fifo_tags;
  logic [1:0]            fifo_count;
  pixel_tags_t           head_tags;
  logic                  pop;
  logic                  headroom_ok;
  logic                  issue;

  assign head_tags = fifo_tags;
  assign pop       = fifo_valid && m_ready_i;

  // Occupancy is judged after this cycle's pop: a pixel leaving now frees
  // the slot the new read will land in two edges later, which is what lets
  // a continuously ready sink receive one pixel per cycle.
  assign headroom_ok = ({1'b0, fifo_count} + {2'b00, inflight_reg})
                       < (3'd2 + {2'b00, pop});
  assign issue       = (state_reg == ST_RUN) && headroom_ok;

  assign issue_tags.sof = (addr_reg == '0);
  assign issue_tags.eol = (col_reg == LAST_COL);
  assign issue_tags.eof = (addr_reg == LAST_ADDR);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (abort_i) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue && (addr_reg == LAST_ADDR)) begin
`ifdef IMAGE_STREAM_LOOP_EN
            state_next = ST_RUN;
`else
            state_next = ST_DRAIN;
`endif
          end
        end
        ST_DRAIN: begin
          if ((fifo_count == 2'd0) && !inflight_reg) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    rd_en_o   = issue;
    busy_o    = (state_reg != ST_IDLE);
    m_valid_o = fifo_valid;
    m_data_o  = fifo_data;
    m_sof_o   = head_tags.sof;
    m_eol_o   = head_tags.eol;
    m_eof_o   = head_tags.eof;
    done_o    = pop && head_tags.eof;
  end

  // ---------------- address / column counters ----------------
  always_comb begin
    addr_next = addr_reg;
    col_next  = col_reg;
    if ((state_reg == ST_IDLE) && start_i) begin
      addr_next = '0;
      col_next  = '0;
    end else if (issue) begin
      // Wrapping at the last address also serves loop mode; in single-shot
      // mode the counter simply rests at 0 through DRAIN.
      addr_next = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;
      col_next  = (col_reg == LAST_COL) ? '0 : col_reg + 1'b1;
    end
  end

  // The tags of a read travel alongside it so they line up with rd_data_i.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      addr_reg          <= '0;
      col_reg           <= '0;
      inflight_reg      <= 1'b0;
      inflight_tags_reg <= '0;
    end else begin
      addr_reg          <= addr_next;
      col_reg           <= col_next;
      inflight_reg      <= issue;
      inflight_tags_reg <= issue_tags;
    end
  end

  assign rd_addr_o = addr_reg;

  // Abort flushes the queue; the read returning on that edge is dropped
  // because the flush wins over the push inside the FIFO.
  image_stream_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (abort_i),
    .push      (inflight_reg),
    .push_data (rd_data_i),
    .push_tags (inflight_tags_reg),
    .pop       (pop),
    .valid     (fifo_valid),
    .data      (fifo_data),
    .tags      (fifo_tags),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_image_stream_reader.sv
module tb_image_stream_reader;

  localparam int AD = 16;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NV = 24;
`ifdef IMAGE_STREAM_LOOP_EN
  localparam int TOTAL = 2 * AD + 8;
`else
  localparam int TOTAL = AD;
`endif

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_i = '0;
  logic          m_valid_o;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] m_data_o;
  logic          m_sof_o, m_eol_o, m_eof_o;
  logic          busy_o, done_o;

  int n_vectors = 0;
  int n_miscompares = 0;
  int reads_issued = 0;

  logic [DW-1:0] mem [AD];

  typedef struct {
    logic          ready;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [2:0]    exp_tags;
    logic          exp_done;
    logic          chk_busy;
    logic          exp_busy;
  } vec_t;

  vec_t vecs [NV];

  image_stream_reader #(
    .ADDR_DEPTH (AD),
    .DATA_WIDTH (DW),
    .H_PIXELS   (H),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .abort_i   (abort_i),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .rd_data_i (rd_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_sof_o   (m_sof_o),
    .m_eol_o   (m_eol_o),
    .m_eof_o   (m_eof_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  // Registered-read image memory preloaded with data = address.
  always @(posedge clk) begin
    if (rd_en_o) begin
      rd_data_i <= mem[rd_addr_o];
    end
  end

  always @(posedge clk) begin
    if (rd_en_o) begin
      reads_issued <= reads_issued + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference tags of pixel index idx within a frame.
  function automatic logic [2:0] exp_tags(input int idx);
    return {idx == 0, (idx % H) == H - 1, idx == AD - 1};
  endfunction

  task automatic check_reset_outputs(input string where);
    chk({where, "_rd_en"},   32'(rd_en_o),   32'(0));
    chk({where, "_rd_addr"}, 32'(rd_addr_o), 32'(0));
    chk({where, "_valid"},   32'(m_valid_o), 32'(0));
    chk({where, "_data"},    32'(m_data_o),  32'(0));
    chk({where, "_tags"},    32'({m_sof_o, m_eol_o, m_eof_o}), 32'(0));
    chk({where, "_busy"},    32'(busy_o),    32'(0));
    chk({where, "_done"},    32'(done_o),    32'(0));
  endtask

  task automatic abort_pulse();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    #1;
  endtask

  // Wait (bounded) until pixel `target` is presented at the output.
  task automatic reach_pixel(input int target, input string name);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (m_valid_o && (m_data_o == DW'(target))) begin
        found = 1'b1;
      end else begin
        tick();
      end
    end
    chk(name, 32'(found), 32'(1));
  endtask

  // Run one frame (or several in loop mode) against the scoreboard model:
  // the accepted stream must be 0,1,2,... mod AD with arithmetic tags.
  // mode 0: ready after `stall` cycles, 1: ready toggles, 2: random ready.
  task automatic run_frame(input int mode, input int stall, input int extra_start_at, input int total);
    int accepted;
    int cycles;
    int issued0;
    int idx;
    logic held;
    logic hs;
    logic [DW+2:0] held_word;
    logic [DW+2:0] word;
    accepted  = 0;
    cycles    = 0;
    held      = 1'b0;
    held_word = '0;
    issued0   = reads_issued;
    start_i   = 1'b1;
    m_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    while (accepted < total && cycles < 600) begin
      case (mode)
        0:       m_ready_i = (cycles >= stall);
        1:       m_ready_i = (cycles % 2 == 0);
        default: m_ready_i = ($urandom_range(0, 2) != 0);
      endcase
      start_i = (cycles == extra_start_at);
      #1;
      idx = accepted % AD;
      if (stall > 0 && cycles == stall) begin
        chk("stall_reads", 32'(reads_issued - issued0), 32'(2));
        chk("stall_head", 32'({m_valid_o, m_data_o}), 32'({1'b1, DW'(0)}));
      end
      chk("read_window", 32'((reads_issued - issued0 - accepted) <= 2), 32'(1));
      word = {m_data_o, m_sof_o, m_eol_o, m_eof_o};
      hs   = m_valid_o && m_ready_i;
      if (held) begin
        chk("stall_stable", 32'({m_valid_o, word}), 32'({1'b1, held_word}));
      end
      chk("done", 32'(done_o), 32'(hs && (idx == AD - 1)));
      if (hs) begin
        chk("pixel", 32'(word), 32'({DW'(idx), exp_tags(idx)}));
        accepted++;
      end
      held      = m_valid_o && !m_ready_i;
      held_word = word;
      tick();
      cycles++;
    end
    start_i = 1'b0;
    chk("frame_complete", 32'(accepted), 32'(total));
`ifdef IMAGE_STREAM_LOOP_EN
    abort_pulse();
    chk("loop_stop", 32'({busy_o, m_valid_o}), 32'(0));
`else
    for (int i = 0; i < 4 && busy_o; i++) begin
      tick();
    end
    chk("frame_idle", 32'({busy_o, m_valid_o}), 32'(0));
`endif
  endtask

  initial begin
    for (int i = 0; i < AD; i++) begin
      mem[i] = DW'(i);
    end

    // Expected cycle-by-cycle outputs after the start edge with ready held 1:
    // two cycles of latency, then one pixel per cycle.
    for (int j = 0; j < NV; j++) begin
      int k;
      k = (j >= 2) ? (j - 2) % AD : 0;
      vecs[j].ready = 1'b1;
`ifdef IMAGE_STREAM_LOOP_EN
      vecs[j].exp_valid = (j >= 2);
      vecs[j].chk_busy  = 1'b1;
      vecs[j].exp_busy  = 1'b1;
`else
      vecs[j].exp_valid = (j >= 2) && (j <= AD + 1);
      vecs[j].chk_busy  = (j <= AD) || (j >= AD + 4);
      vecs[j].exp_busy  = (j <= AD);
`endif
      vecs[j].exp_data = DW'(k);
      vecs[j].exp_tags = exp_tags(k);
      vecs[j].exp_done = vecs[j].exp_valid && (k == AD - 1);
    end

    // Reset state
    rst_i = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick();
    check_reset_outputs("post_reset");

    // Table-driven frame with a continuously ready sink
    start_i   = 1'b1;
    m_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int j = 0; j < NV; j++) begin
      m_ready_i = vecs[j].ready;
      #1;
      chk($sformatf("vec%0d_valid", j), 32'(m_valid_o), 32'(vecs[j].exp_valid));
      if (vecs[j].exp_valid) begin
        chk($sformatf("vec%0d_pixel", j), 32'({m_data_o, m_sof_o, m_eol_o, m_eof_o}),
            32'({vecs[j].exp_data, vecs[j].exp_tags}));
      end
      chk($sformatf("vec%0d_done", j), 32'(done_o), 32'(vecs[j].exp_done));
      if (vecs[j].chk_busy) begin
        chk($sformatf("vec%0d_busy", j), 32'(busy_o), 32'(vecs[j].exp_busy));
      end
      tick();
    end
`ifdef IMAGE_STREAM_LOOP_EN
    abort_pulse();
`endif
    tick();

    // Ready toggling every cycle
    run_frame(1, 0, -1, TOTAL);

    // Sink stalled for 10 cycles after start
    run_frame(0, 10, -1, TOTAL);

    // Abort at pixel 5, then restart from 0
    start_i   = 1'b1;
    m_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    reach_pixel(5, "abort_reach_px5");
    abort_pulse();
    chk("abort_valid", 32'(m_valid_o), 32'(0));
    chk("abort_busy", 32'(busy_o), 32'(0));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("abort_flushed", 32'({m_valid_o, busy_o, rd_en_o}), 32'(0));
    end
    run_frame(0, 0, -1, TOTAL);

    // Abort wins over a simultaneous start
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    #1;
    chk("abort_over_start_busy", 32'(busy_o), 32'(0));
    tick();
    chk("abort_over_start_quiet", 32'({m_valid_o, rd_en_o}), 32'(0));

    // Reset at pixel 7
    start_i   = 1'b1;
    m_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    reach_pixel(7, "reset_reach_px7");
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_reset_outputs("midframe_reset");
    tick();

    // A start pulse while busy must not disturb the running frame
    run_frame(0, 0, 5, TOTAL);

    // Random back-pressure
    for (int r = 0; r < 4; r++) begin
      run_frame(2, 0, -1, TOTAL);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
